// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL reset/lock sequencer.
//   seq_state_t : sequencer states, in bring-up order
//   RETRY_W     : width of the failed-attempt counter (o_retries)
// ---------------------------------------------------------------------------
package pll_seq_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop single-bit synchroniser for a level signal that is
// asynchronous to i_clk. Output is delayed by two i_clk edges.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : synchronous active-low reset, clears both flops
//   i_d     : asynchronous input level
//   o_q     : synchronised output level
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  // [0] is the metastability-catching flop, [1] is the clean output.
  logic [1:0] sync_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], i_d};
    end
  end

  assign o_q = sync_reg[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
// Drives the board PLL through reset, qualifies its lock indication, and
// releases a stretched active-high system reset once lock is trustworthy.
// Lock timeouts and lock loss during hold are retried a bounded number of
// times before the sequencer parks in FAIL.
//
// Build option:
//   PLL_RELOCK_EN  defined   : lock loss in RUN restarts the full sequence
//                  undefined : lock loss in RUN goes straight to FAIL
//
// Ports:
//   i_clk     : free-running reference clock (only clock)
//   i_rst_n   : synchronous active-low reset
//   i_locked  : PLL lock, asynchronous to i_clk
//   o_pll_rst : reset to the PLL, active-high
//   o_sys_rst : system reset, active-high
//   o_ready   : high only in RUN
//   o_fail    : high only in FAIL (sticky until i_rst_n)
//   o_retries : failed attempts since reset, saturates at MAX_RETRIES
// ---------------------------------------------------------------------------
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int RST_HOLD       = 256,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_locked,
  output logic               o_pll_rst,
  output logic               o_sys_rst,
  output logic               o_ready,
  output logic               o_fail,
  output logic [RETRY_W-1:0] o_retries
);

  // Terminal counts: the counter starts at 0 on state entry, so a phase of
  // N cycles ends when the counter equals N-1.
  localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

  seq_state_t         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [RETRY_W-1:0] retries_reg, retries_next;
  logic               pll_rst_reg, pll_rst_next;
  logic               sys_rst_reg, sys_rst_next;
  logic               ready_reg, ready_next;
  logic               fail_reg, fail_next;
  logic               lk;
  logic               retry;

  sync_2ff u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_locked),
    .o_q     (lk)
  );

  always_comb begin
    state_next   = state_reg;
    retries_next = retries_reg;
    retry        = 1'b0;

    // In every state the lk test is evaluated before the terminal count,
    // so a lock change on the same cycle as a terminal count takes priority.
    case (state_reg)
      PLL_RST: begin
        if (cnt_reg == PLL_RST_LAST) begin
          state_next = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_next = STABLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          retry = 1'b1;
        end
      end
      STABLE: begin
        // A dropout while qualifying is not counted as a failed attempt;
        // re-entering WAIT_LOCK restarts the timeout.
        if (!lk) begin
          state_next = WAIT_LOCK;
        end else if (cnt_reg == STABLE_LAST) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!lk) begin
          retry = 1'b1;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next   = RUN;
          retries_next = '0;
        end
      end
      RUN: begin
        if (!lk) begin
`ifdef PLL_RELOCK_EN
          state_next = PLL_RST;
`else
          state_next = FAIL;
`endif
        end
      end
      FAIL: begin
        state_next = FAIL;
      end
      default: begin
        state_next = PLL_RST;
      end
    endcase

    if (retry) begin
      retries_next = retries_reg + RETRY_W'(1);
      state_next   = (retries_reg == RETRY_LAST) ? FAIL : PLL_RST;
    end

    // One shared counter: cleared on every transition, frozen in the
    // states that never look at it so it cannot wrap.
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if ((state_reg == RUN) || (state_reg == FAIL)) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    // Outputs are decoded from the next state so they move on the same
    // edge as the state register.
    pll_rst_next = (state_next == PLL_RST) || (state_next == FAIL);
    sys_rst_next = (state_next != RUN);
    ready_next   = (state_next == RUN);
    fail_next    = (state_next == FAIL);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= PLL_RST;
      cnt_reg     <= '0;
      retries_reg <= '0;
      pll_rst_reg <= 1'b1;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
      fail_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retries_reg <= retries_next;
      pll_rst_reg <= pll_rst_next;
      sys_rst_reg <= sys_rst_next;
      ready_reg   <= ready_next;
      fail_reg    <= fail_next;
    end
  end

  assign o_pll_rst = pll_rst_reg;
  assign o_sys_rst = sys_rst_reg;
  assign o_ready   = ready_reg;
  assign o_fail    = fail_reg;
  assign o_retries = retries_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Scenario-based bench with randomised lock timing. Expected cycle counts
// are derived from the sequencer's timing rules: lock is seen two edges
// after it is sampled, qualification takes LOCK_STABLE cycles, the reset
// hold takes RST_HOLD cycles, a PLL reset pulse lasts PLL_RST_CYCLES and a
// lock wait times out after LOCK_TIMEOUT cycles.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int P_PLL_RST = 4;
  localparam int P_TIMEOUT = 20;
  localparam int P_STABLE  = 8;
  localparam int P_HOLD    = 5;
  localparam int P_MAX     = 3;
  localparam int LK_LAT    = 2;   // synchroniser latency in edges
  localparam int BOUND     = 200; // cycle budget for any single wait

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retries;

  int checks = 0;
  int passed = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (P_PLL_RST),
    .LOCK_TIMEOUT   (P_TIMEOUT),
    .LOCK_STABLE    (P_STABLE),
    .RST_HOLD       (P_HOLD),
    .MAX_RETRIES    (P_MAX),
    .CNT_W          (16)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_locked  (locked),
    .o_pll_rst (pll_rst),
    .o_sys_rst (sys_rst),
    .o_ready   (ready),
    .o_fail    (fail),
    .o_retries (retries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling / driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  // Number of consecutive samples (current one included) with o_pll_rst high.
  task automatic measure_high(output int len);
    len = 0;
    while (pll_rst === 1'b1 && len < BOUND) begin
      len++;
      tick();
    end
  endtask

  task automatic measure_low(output int len);
    len = 0;
    while (pll_rst === 1'b0 && len < BOUND) begin
      len++;
      tick();
    end
  endtask

  // Called right after i_locked is raised. Returns edges from the first
  // edge sampling the rise until o_sys_rst is low.
  task automatic wait_release(output int k);
    k = 0;
    tick();
    while (sys_rst !== 1'b0 && k < BOUND) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    int n;
    n      = $urandom_range(1, 4);
    locked = 1'($urandom_range(0, 1));
    rst_n  = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if ({pll_rst, sys_rst, ready, fail, retries} !== 8'b1100_0000)
        $display("FAIL reset_values: got %b expected %b",
                 {pll_rst, sys_rst, ready, fail, retries}, 8'b1100_0000);
      else passed++;
    end
    rst_n  = 1'b1;
    locked = 1'b0;
    $display("test_reset: %0d reset cycles", n);
  endtask

  task automatic test_clean_bringup();
    int d, len, k;
    for (int it = 0; it < 4; it++) begin
      // first pass uses the nominal delay, last pass locks on the very
      // cycle the lock wait would time out
      d = (it == 0) ? 3 : (it == 3) ? (P_TIMEOUT - LK_LAT - 1) : int'($urandom_range(0, 12));
      locked = 1'b0;
      apply_reset($urandom_range(1, 3));
      measure_high(len);
      checks++;
      if (len !== P_PLL_RST) $display("FAIL bringup_pulse: got %0d cycles expected %0d", len, P_PLL_RST);
      else passed++;
      repeat (d) tick();
      locked = 1'b1;
      wait_release(k);
      checks++;
      if (k !== LK_LAT + P_STABLE + P_HOLD)
        $display("FAIL bringup_release: got %0d edges expected %0d", k, LK_LAT + P_STABLE + P_HOLD);
      else passed++;
      checks++;
      if ({ready, pll_rst, fail, retries} !== 7'b100_0000)
        $display("FAIL bringup_run_outputs: got %b expected %b", {ready, pll_rst, fail, retries}, 7'b100_0000);
      else passed++;
      $display("test_clean_bringup: lock delay %0d pulse %0d release after %0d", d, len, k);
    end
  endtask

  task automatic test_never_locks();
    int len, low;
    bit bad;
    locked = 1'b0;
    apply_reset(2);
    for (int a = 0; a < P_MAX; a++) begin
      measure_high(len);
      checks++;
      if (len !== P_PLL_RST || retries !== 4'(a))
        $display("FAIL nolock_pulse%0d: got len %0d retries %0d expected len %0d retries %0d",
                 a, len, retries, P_PLL_RST, a);
      else passed++;
      measure_low(low);
      checks++;
      if (low !== P_TIMEOUT) $display("FAIL nolock_gap%0d: got %0d expected %0d", a, low, P_TIMEOUT);
      else passed++;
    end
    checks++;
    if ({fail, pll_rst, sys_rst, ready, retries} !== {4'b1110, 4'(P_MAX)})
      $display("FAIL nolock_fail_entry: got %b expected %b",
               {fail, pll_rst, sys_rst, ready, retries}, {4'b1110, 4'(P_MAX)});
    else passed++;
    // FAIL must hold whatever the lock input does afterwards
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      locked = 1'($urandom_range(0, 1));
      tick();
      if ({fail, pll_rst, sys_rst, ready, retries} !== {4'b1110, 4'(P_MAX)}) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL nolock_sticky: got %b expected %b",
                      {fail, pll_rst, sys_rst, ready, retries}, {4'b1110, 4'(P_MAX)});
    else passed++;
    $display("test_never_locks: fail=%0b retries=%0d", fail, retries);
  endtask

  task automatic test_stable_glitch();
    int d, h, l, len, k;
    for (int it = 0; it < 3; it++) begin
      d = $urandom_range(0, 5);
      h = (it == 0) ? 5 : int'($urandom_range(1, P_STABLE - 1));
      l = (it == 0) ? 1 : int'($urandom_range(1, 3));
      locked = 1'b0;
      apply_reset(1);
      measure_high(len);
      repeat (d) tick();
      locked = 1'b1;
      repeat (h) tick();
      locked = 1'b0;
      repeat (l) tick();
      checks++;
      if ({pll_rst, sys_rst, retries} !== 6'b01_0000)
        $display("FAIL glitch_no_retry: got %b expected %b", {pll_rst, sys_rst, retries}, 6'b01_0000);
      else passed++;
      locked = 1'b1;
      wait_release(k);
      checks++;
      if (k !== LK_LAT + P_STABLE + P_HOLD || retries !== 4'd0)
        $display("FAIL glitch_release: got %0d edges retries %0d expected %0d edges retries 0",
                 k, retries, LK_LAT + P_STABLE + P_HOLD);
      else passed++;
      $display("test_stable_glitch: high %0d low %0d release after %0d", h, l, k);
    end
  endtask

  task automatic test_drop_in_hold();
    int d, j, len;
    d = $urandom_range(0, 8);
    j = $urandom_range(0, 2);
    locked = 1'b0;
    apply_reset(1);
    measure_high(len);
    repeat (d) tick();
    locked = 1'b1;
    tick();
    repeat (LK_LAT + P_STABLE + j) tick();   // now in HOLD
    locked = 1'b0;
    tick();
    tick();
    checks++;
    if ({pll_rst, sys_rst} !== 2'b01) $display("FAIL hold_drop_latency: got %b expected %b", {pll_rst, sys_rst}, 2'b01);
    else passed++;
    tick();
    checks++;
    if ({pll_rst, sys_rst, ready, retries} !== 7'b110_0001)
      $display("FAIL hold_drop_retry: got %b expected %b", {pll_rst, sys_rst, ready, retries}, 7'b110_0001);
    else passed++;
    $display("test_drop_in_hold: drop %0d cycles into HOLD retries=%0d", j, retries);
  endtask

  task automatic test_loss_in_run();
    int d, len, k;
    bit bad;
    d = $urandom_range(0, 10);
    locked = 1'b0;
    apply_reset(1);
    measure_high(len);
    repeat (d) tick();
    locked = 1'b1;
    wait_release(k);
    checks++;
    if (k !== LK_LAT + P_STABLE + P_HOLD) $display("FAIL loss_bringup: got %0d expected %0d", k, LK_LAT + P_STABLE + P_HOLD);
    else passed++;
    repeat ($urandom_range(0, 4)) tick();
    locked = 1'b0;
    tick();
    tick();
    checks++;
    if ({sys_rst, ready} !== 2'b01) $display("FAIL loss_edge2: got %b expected %b", {sys_rst, ready}, 2'b01);
    else passed++;
    tick();
    checks++;
    if ({sys_rst, ready} !== 2'b10) $display("FAIL loss_edge3: got %b expected %b", {sys_rst, ready}, 2'b10);
    else passed++;
`ifdef PLL_RELOCK_EN
    checks++;
    if ({pll_rst, fail, retries} !== 6'b10_0000)
      $display("FAIL relock_entry: got %b expected %b", {pll_rst, fail, retries}, 6'b10_0000);
    else passed++;
    measure_high(len);
    checks++;
    if (len !== P_PLL_RST) $display("FAIL relock_pulse: got %0d expected %0d", len, P_PLL_RST);
    else passed++;
    repeat ($urandom_range(0, 10)) tick();
    locked = 1'b1;
    wait_release(k);
    checks++;
    if (k !== LK_LAT + P_STABLE + P_HOLD || ready !== 1'b1)
      $display("FAIL relock_release: got %0d edges ready %b expected %0d edges ready 1", k, ready, LK_LAT + P_STABLE + P_HOLD);
    else passed++;
    $display("test_loss_in_run: relock pulse %0d release after %0d", len, k);
`else
    checks++;
    if ({fail, pll_rst, retries} !== 6'b11_0000)
      $display("FAIL loss_fail_entry: got %b expected %b", {fail, pll_rst, retries}, 6'b11_0000);
    else passed++;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      locked = 1'($urandom_range(0, 1));
      tick();
      if ({fail, pll_rst, sys_rst, ready} !== 4'b1110) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL loss_sticky: got %b expected %b", {fail, pll_rst, sys_rst, ready}, 4'b1110);
    else passed++;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({pll_rst, sys_rst, ready, fail, retries} !== 8'b1100_0000)
      $display("FAIL loss_reset_exit: got %b expected %b", {pll_rst, sys_rst, ready, fail, retries}, 8'b1100_0000);
    else passed++;
    rst_n = 1'b1;
    $display("test_loss_in_run: fail latched, cleared by reset");
`endif
  endtask

  task automatic test_reset_mid_hold();
    int d, j, len, low;
    d = $urandom_range(0, 8);
    j = $urandom_range(0, P_HOLD - 1);
    locked = 1'b0;
    apply_reset(1);
    measure_high(len);
    measure_low(low);
    checks++;
    if (low !== P_TIMEOUT || retries !== 4'd1)
      $display("FAIL midhold_timeout: got gap %0d retries %0d expected gap %0d retries 1", low, retries, P_TIMEOUT);
    else passed++;
    measure_high(len);
    repeat (d) tick();
    locked = 1'b1;
    tick();
    repeat (LK_LAT + P_STABLE + j) tick();   // in HOLD
    checks++;
    if ({pll_rst, sys_rst, ready, retries} !== 7'b010_0001)
      $display("FAIL midhold_in_hold: got %b expected %b", {pll_rst, sys_rst, ready, retries}, 7'b010_0001);
    else passed++;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({pll_rst, sys_rst, ready, fail, retries} !== 8'b1100_0000)
      $display("FAIL midhold_reset: got %b expected %b", {pll_rst, sys_rst, ready, fail, retries}, 8'b1100_0000);
    else passed++;
    rst_n = 1'b1;
    measure_high(len);
    checks++;
    if (len !== P_PLL_RST) $display("FAIL midhold_restart_pulse: got %0d expected %0d", len, P_PLL_RST);
    else passed++;
    $display("test_reset_mid_hold: reset %0d cycles into HOLD, restart pulse %0d", j, len);
  endtask

  initial begin
    rst_n  = 1'b0;
    locked = 1'b0;
    test_reset();
    test_clean_bringup();
    test_never_locks();
    test_stable_glitch();
    test_drop_in_hold();
    test_loss_in_run();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
